car_direction_detector: RTL
===========================

Name: car_direction_detector

Overview:
Input stage of the parking-lot car counter; sits directly upstream of the counter/display logic and drives it.
- Synchronises and debounces the two laser beam sensors.
- Tracks the sensor pattern sequence with an FSM.
- Emits one-cycle enter/exit pulses that the downstream occupancy counter consumes; flags illegal sensor patterns.

Parameters:
SYNC_STAGES, 2, flip-flop stages per sensor bit in the input synchroniser (min 2)
DEBOUNCE_CYCLES, 2, consecutive clocks a synchronised value must differ from the clean value before it is accepted (min 1)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
lasers  in  2  raw sensors, 1 = beam blocked; bit0 = sensor A (street side), bit1 = sensor B (lot side)
lasers_clean  out  2  synchronised + debounced sensor value
enter  out  1  one-cycle pulse: a car completed entry
exit  out  1  one-cycle pulse: a car completed exit
error  out  1  one-cycle pulse: illegal two-bit jump in lasers_clean
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset (async, rst=1):
  - Synchroniser flops = 0, lasers_clean = 00, debounce counters = 0.
  - state = IDLE; enter/exit/error = 0; state_dbg = 0.
  - Asserting rst mid-sequence aborts it with no pulse.
- Synchroniser: per-bit chain of SYNC_STAGES flops.
- Debounce, per bit independently:
  - Counter clears whenever synced == clean.
  - Counter increments while synced != clean.
  - clean takes synced on the edge where the counter reaches DEBOUNCE_CYCLES; the counter then clears.
  - Latency: a raw change stable from edge k appears on lasers_clean after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1 (k+3 with defaults).
  - Glitches shorter than DEBOUNCE_CYCLES cycles after the synchroniser are discarded.
- FSM, evaluated on lasers_clean (written BA). Encoding: IDLE=0, EN1=1, EN2=2, EN3=3, EX1=4, EX2=5, EX3=6, WAIT_CLEAR=7.
  - IDLE: 01->EN1; 10->EX1; 00 stay; 11->WAIT_CLEAR with error.
  - EN1 (A only): 11->EN2; 00->IDLE (abort, no pulse); 01 stay; 10 illegal.
  - EN2 (both): 10->EN3; 01->EN1 (backed out); 11 stay; 00 illegal.
  - EN3 (B only): 00->IDLE with enter=1; 11->EN2; 10 stay; 01 illegal.
  - EX1 / EX2 / EX3: mirror of EN1 / EN2 / EN3 with A and B swapped (10, 11, 01); EX3 00->IDLE with exit=1.
  - Illegal = both bits of lasers_clean changed on one edge. Response: error=1 for one cycle; next state IDLE if clean==00, else WAIT_CLEAR.
  - WAIT_CLEAR: stays until clean==00, then IDLE; no pulses.
- Pulses:
  - enter, exit and error are registered; each is set on the same edge as the causing transition and cleared on the next edge.
  - Never more than one pulse high in a cycle; enter and exit are never simultaneous.
  - Only a complete forward or reverse 4-phase sequence produces a pulse. Partial, aborted or backed-out sequences produce none.
- state_dbg mirrors the state register combinationally.

Test Plan:
- Reset: rst=1 for 3 cycles, with lasers toggling during reset -> all outputs 0, state_dbg=0; after release, nothing changes until lasers differs from 00.
- Entry: lasers 01,11,10,00, each held 3 clk, repeated 5 times -> exactly 5 enter pulses of 1 cycle, 0 exit, 0 error; each pulse 3 cycles after raw lasers returns to 00 (defaults).
- Exit: lasers 10,11,01,00, each held 3 clk, repeated 3 times -> exactly 3 exit pulses, 0 enter; state_dbg steps 4,5,6,0.
- Abort/back-out:
  - 01,00 -> no pulse, state_dbg back to 0.
  - 01,11,01,11,10,00 -> exactly 1 enter.
- Glitch/illegal:
  - 1-cycle raw pulse 01 -> lasers_clean stays 00, no state change.
  - Raw 00->11 held 3 clk -> 1 error pulse, state_dbg=7 until 00, then 0; no enter/exit.
- Reset mid-operation: assert rst while in EN2 (state_dbg=2) -> immediate (async) state_dbg=0, lasers_clean=00; completing 10,00 afterwards gives no enter.

Source files
------------

// File: rtl/car_direction_detector.sv
// car_direction_detector
// Input stage of the parking-lot car counter. Synchronises and debounces the
// two laser sensors (bit0 = A street side, bit1 = B lot side), follows the
// beam pattern through a 4-phase sequence and emits one-cycle enter/exit
// pulses for the occupancy counter, plus an error pulse on illegal jumps.
//
// state      | meaning
// -----------+---------------------------------------------
// IDLE  (0)  | no beam blocked
// EN1   (1)  | entering, A only blocked
// EN2   (2)  | entering, both blocked
// EN3   (3)  | entering, B only blocked
// EX1   (4)  | exiting, B only blocked
// EX2   (5)  | exiting, both blocked
// EX3   (6)  | exiting, A only blocked
// WAIT  (7)  | after an illegal jump, wait for both beams clear
module car_direction_detector #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] lasers_i,
  output logic [1:0] lasers_clean_o,
  output logic       enter_o,
  output logic       exit_o,
  output logic       error_o,
  output logic [2:0] state_dbg_o
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EN1  = 3'd1;
  localparam logic [2:0] S_EN2  = 3'd2;
  localparam logic [2:0] S_EN3  = 3'd3;
  localparam logic [2:0] S_EX1  = 3'd4;
  localparam logic [2:0] S_EX2  = 3'd5;
  localparam logic [2:0] S_EX3  = 3'd6;
  localparam logic [2:0] S_WAIT = 3'd7;

  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0]                  synced;
  logic [1:0][CW-1:0]          cnt_q, cnt_d;
  logic [1:0]                  clean_q, clean_d;
  logic [2:0]                  state_q, state_d;
  logic                        enter_q, enter_d;
  logic                        exit_q, exit_d;
  logic                        error_q, error_d;
  logic                        illegal;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the raw sensors, later stages shift.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= lasers_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Debounce per bit: accept the synced value once it has disagreed with the
  // clean value for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = '0;
    for (int b = 0; b < 2; b++) begin
      if (synced[b] != clean_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          clean_d[b] = synced[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CW'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      clean_q <= 2'b00;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  // Sequence FSM. It looks at the clean value being loaded on this edge so
  // that state and pulses move on the same edge as lasers_clean does.
  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    error_d = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_IDLE: begin
        case (clean_d)
          2'b01:   state_d = S_EN1;
          2'b10:   state_d = S_EX1;
          2'b11:   illegal = 1'b1;
          default: state_d = S_IDLE;
        endcase
      end
      S_EN1: begin
        case (clean_d)
          2'b11:   state_d = S_EN2;
          2'b00:   state_d = S_IDLE;
          2'b10:   illegal = 1'b1;
          default: state_d = S_EN1;
        endcase
      end
      S_EN2: begin
        case (clean_d)
          2'b10:   state_d = S_EN3;
          2'b01:   state_d = S_EN1;
          2'b00:   illegal = 1'b1;
          default: state_d = S_EN2;
        endcase
      end
      S_EN3: begin
        case (clean_d)
          2'b00: begin
            state_d = S_IDLE;
            enter_d = 1'b1;
          end
          2'b11:   state_d = S_EN2;
          2'b01:   illegal = 1'b1;
          default: state_d = S_EN3;
        endcase
      end
      S_EX1: begin
        case (clean_d)
          2'b11:   state_d = S_EX2;
          2'b00:   state_d = S_IDLE;
          2'b01:   illegal = 1'b1;
          default: state_d = S_EX1;
        endcase
      end
      S_EX2: begin
        case (clean_d)
          2'b01:   state_d = S_EX3;
          2'b10:   state_d = S_EX1;
          2'b00:   illegal = 1'b1;
          default: state_d = S_EX2;
        endcase
      end
      S_EX3: begin
        case (clean_d)
          2'b00: begin
            state_d = S_IDLE;
            exit_d  = 1'b1;
          end
          2'b11:   state_d = S_EX2;
          2'b10:   illegal = 1'b1;
          default: state_d = S_EX3;
        endcase
      end
      default: begin
        if (clean_d == 2'b00) begin
          state_d = S_IDLE;
        end
      end
    endcase
    if (illegal) begin
      error_d = 1'b1;
      state_d = (clean_d == 2'b00) ? S_IDLE : S_WAIT;
    end
  end

  // State and registered one-cycle pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      error_q <= error_d;
    end
  end

  assign lasers_clean_o = clean_q;
  assign enter_o        = enter_q;
  assign exit_o         = exit_q;
  assign error_o        = error_q;
  assign state_dbg_o    = state_q;

endmodule
